// File: rtl/nios2_small_mem_bist_master_if.sv
// ---------------------------------------------------------------------------
// nios2_small_mem_bist_master_if
// Avalon-MM bus bundle between the BIST master and the on-chip RAM s1 port.
//   avm_address        word address (AW bits)
//   avm_chipselect     high with any read or write
//   avm_write          write strobe
//   avm_read           read strobe
//   avm_byteenable     byte lanes, 4 bits
//   avm_writedata      write data, 32 bits
//   avm_readdata       read data, 32 bits
//   avm_waitrequest    slave stall; the master holds its command while high
//   avm_readdatavalid  qualifies avm_readdata
// Modports: master (drives the command side), slave (drives the response).
// ---------------------------------------------------------------------------
interface nios2_small_mem_bist_master_if #(
  parameter int AW = 14
);
  logic [AW-1:0] avm_address;
  logic          avm_chipselect;
  logic          avm_write;
  logic          avm_read;
  logic [3:0]    avm_byteenable;
  logic [31:0]   avm_writedata;
  logic [31:0]   avm_readdata;
  logic          avm_waitrequest;
  logic          avm_readdatavalid;

  modport master (
    output avm_address, avm_chipselect, avm_write, avm_read,
           avm_byteenable, avm_writedata,
    input  avm_readdata, avm_waitrequest, avm_readdatavalid
  );

  modport slave (
    input  avm_address, avm_chipselect, avm_write, avm_read,
           avm_byteenable, avm_writedata,
    output avm_readdata, avm_waitrequest, avm_readdatavalid
  );
endinterface

// File: rtl/nios2_small_mem_bist_master.sv
// ---------------------------------------------------------------------------
// nios2_small_mem_bist_master
// Avalon-MM master that fills a word-addressed on-chip memory with a pattern
// and, in verify mode, reads every word back and counts mismatches.
// Ports:
//   clk, reset_n        clock and synchronous active-low reset
//   start_i             begin a run (only looked at while idle)
//   mode_i              0 = fill only, 1 = fill then verify
//   base_addr_i         first word address
//   num_words_i         number of words (0 allowed)
//   seed_i              pattern seed
//   busy_o              run in progress
//   done_o              one-cycle end-of-run pulse
//   pass_o              no mismatches in the last run, held until next start
//   err_count_o         saturating mismatch count
//   first_err_addr_o    address of the first mismatch (0 if none)
//   bus                 Avalon-MM master side (nios2_small_mem_bist_master_if)
// Configuration macro: MEM_BIST_LFSR_EN selects a 32-bit Galois LFSR pattern
// instead of the default seed ^ {~i, i} pattern.
// ---------------------------------------------------------------------------
module nios2_small_mem_bist_master #(
  parameter int AW    = 14,
  parameter int DEPTH = 10240,
  parameter int ECW   = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start_i,
  input  logic                mode_i,
  input  logic [AW-1:0]       base_addr_i,
  input  logic [AW:0]         num_words_i,
  input  logic [31:0]         seed_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                pass_o,
  output logic [ECW-1:0]      err_count_o,
  output logic [AW-1:0]       first_err_addr_o,
  nios2_small_mem_bist_master_if.master bus
);

  typedef enum logic [2:0] {IDLE, WR, RD_REQ, RD_WAIT, FIN} state_t;

  localparam logic [AW-1:0] LAST_ADDR  = AW'(DEPTH - 1);
  localparam logic [AW-1:0] DEPTH_ADDR = AW'(DEPTH);

  state_t          state_q, state_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [AW-1:0]   baseAddr_q, baseAddr_d;
  logic [AW:0]     idx_q, idx_d;
  logic [AW:0]     numWords_q, numWords_d;
  logic [31:0]     seed_q, seed_d;
  logic            mode_q, mode_d;
  logic [ECW-1:0]  errCount_q, errCount_d;
  logic [AW-1:0]   firstErrAddr_q, firstErrAddr_d;
  logic            pass_q, pass_d;

  logic [31:0]     pattern;
  logic [AW-1:0]   addrInc;
  logic [AW-1:0]   baseWrapped;
  logic [AW:0]     idxInc;
  logic            lastWord;

`ifdef MEM_BIST_LFSR_EN
  localparam logic [31:0] LFSR_POLY = 32'h80200003;
  logic [31:0] lfsr_q, lfsr_d;
  logic [31:0] lfsrNext;
  logic [31:0] seedClean;
`else
  logic [15:0] idxLow;
`endif

  // Next-state logic. The bus command is a pure function of the registered
  // state, so it stays frozen for as long as waitrequest keeps us in place.
  always_comb begin
    state_d        = state_q;
    addr_d         = addr_q;
    baseAddr_d     = baseAddr_q;
    idx_d          = idx_q;
    numWords_d     = numWords_q;
    seed_d         = seed_q;
    mode_d         = mode_q;
    errCount_d     = errCount_q;
    firstErrAddr_d = firstErrAddr_q;
    pass_d         = pass_q;

    // A base at or beyond DEPTH is folded back into range once, on latch;
    // 2**AW < 2*DEPTH keeps a single subtraction sufficient.
    baseWrapped = (base_addr_i >= DEPTH_ADDR) ? (base_addr_i - DEPTH_ADDR) : base_addr_i;
    addrInc     = (addr_q == LAST_ADDR) ? '0 : (addr_q + AW'(1));
    idxInc      = idx_q + (AW+1)'(1);
    lastWord    = (idxInc == numWords_q);

`ifdef MEM_BIST_LFSR_EN
    lfsr_d    = lfsr_q;
    lfsrNext  = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? LFSR_POLY : 32'h0);
    seedClean = (seed_i == 32'h0) ? 32'h1 : seed_i;
    pattern   = lfsr_q;
`else
    idxLow  = 16'(idx_q);
    pattern = seed_q ^ {~idxLow, idxLow};
`endif

    case (state_q)
      IDLE: begin
        if (start_i) begin
          baseAddr_d     = baseWrapped;
          addr_d         = baseWrapped;
          numWords_d     = num_words_i;
          mode_d         = mode_i;
          errCount_d     = '0;
          firstErrAddr_d = '0;
          pass_d         = 1'b0;
          idx_d          = '0;
`ifdef MEM_BIST_LFSR_EN
          seed_d = seedClean;
          lfsr_d = seedClean;
`else
          seed_d = seed_i;
`endif
          state_d = (num_words_i == '0) ? FIN : WR;
        end
      end

      WR: begin
        if (!bus.avm_waitrequest) begin
          idx_d  = idxInc;
          addr_d = addrInc;
`ifdef MEM_BIST_LFSR_EN
          lfsr_d = lfsrNext;
`endif
          if (lastWord) begin
            if (mode_q) begin
              state_d = RD_REQ;
              idx_d   = '0;
              addr_d  = baseAddr_q;
`ifdef MEM_BIST_LFSR_EN
              lfsr_d = seed_q;
`endif
            end else begin
              state_d = FIN;
            end
          end
        end
      end

      RD_REQ: begin
        if (!bus.avm_waitrequest) begin
          state_d = RD_WAIT;
        end
      end

      // Only one read is ever in flight, so the returning word always
      // belongs to the current index.
      RD_WAIT: begin
        if (bus.avm_readdatavalid) begin
          if (bus.avm_readdata != pattern) begin
            if (errCount_q != '1) begin
              errCount_d = errCount_q + ECW'(1);
            end
            if (errCount_q == '0) begin
              firstErrAddr_d = addr_q;
            end
          end
          idx_d  = idxInc;
          addr_d = addrInc;
`ifdef MEM_BIST_LFSR_EN
          lfsr_d = lfsrNext;
`endif
          state_d = lastWord ? FIN : RD_REQ;
        end
      end

      FIN: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Pass is settled on entry to FIN so it is already valid alongside done.
    if (state_d == FIN && state_q != FIN) begin
      pass_d = (errCount_d == '0);
    end
  end

  // State register with synchronous reset; a reset mid-run simply drops
  // the FSM back to IDLE, which removes every strobe on the next cycle.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      addr_q         <= '0;
      baseAddr_q     <= '0;
      idx_q          <= '0;
      numWords_q     <= '0;
      seed_q         <= '0;
      mode_q         <= 1'b0;
      errCount_q     <= '0;
      firstErrAddr_q <= '0;
      pass_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      addr_q         <= addr_d;
      baseAddr_q     <= baseAddr_d;
      idx_q          <= idx_d;
      numWords_q     <= numWords_d;
      seed_q         <= seed_d;
      mode_q         <= mode_d;
      errCount_q     <= errCount_d;
      firstErrAddr_q <= firstErrAddr_d;
      pass_q         <= pass_d;
    end
  end

`ifdef MEM_BIST_LFSR_EN
  // Pattern generator state, advanced once per completed word.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      lfsr_q <= '0;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end
`endif

  // Writedata is gated so the bus shows zero whenever no write is pending.
  always_comb begin
    busy_o             = (state_q != IDLE);
    done_o             = (state_q == FIN);
    pass_o             = pass_q;
    err_count_o        = errCount_q;
    first_err_addr_o   = firstErrAddr_q;
    bus.avm_address    = addr_q;
    bus.avm_chipselect = (state_q == WR) || (state_q == RD_REQ);
    bus.avm_write      = (state_q == WR);
    bus.avm_read       = (state_q == RD_REQ);
    bus.avm_byteenable = 4'hF;
    bus.avm_writedata  = (state_q == WR) ? pattern : 32'h0;
  end

endmodule

// File: tb/tb_nios2_small_mem_bist_master.sv
// ---------------------------------------------------------------------------
// tb_nios2_small_mem_bist_master
// Self-checking bench for nios2_small_mem_bist_master (default pattern build,
// MEM_BIST_LFSR_EN undefined). A word RAM model answers the Avalon port with
// read latency 1, optional write stalls and an optional single-bit fault.
// Expected bus transactions are queued when a run is launched and matched
// against the transactions the monitor captures.
// ---------------------------------------------------------------------------
module tb_nios2_small_mem_bist_master;

  localparam int AW    = 14;
  localparam int DEPTH = 10240;
  localparam int ECW   = 16;

  typedef struct {
    logic          isRead;
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } txn_t;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            start;
  logic            mode;
  logic [AW-1:0]   baseAddr;
  logic [AW:0]     numWords;
  logic [31:0]     seed;
  logic            busy;
  logic            done;
  logic            pass;
  logic [ECW-1:0]  errCount;
  logic [AW-1:0]   firstErrAddr;

  nios2_small_mem_bist_master_if #(.AW(AW)) busIf ();

  nios2_small_mem_bist_master #(.AW(AW), .DEPTH(DEPTH), .ECW(ECW)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .start_i          (start),
    .mode_i           (mode),
    .base_addr_i      (baseAddr),
    .num_words_i      (numWords),
    .seed_i           (seed),
    .busy_o           (busy),
    .done_o           (done),
    .pass_o           (pass),
    .err_count_o      (errCount),
    .first_err_addr_o (firstErrAddr),
    .bus              (busIf.slave)
  );

  always #5 clk = ~clk;

  int            compared   = 0;
  int            mismatched = 0;
  int            stallWant  = 0;
  int            writeCycles = 0;
  logic          faultEn   = 1'b0;
  logic [AW-1:0] faultAddr = '0;
  logic [31:0]   mem [0:DEPTH-1];
  logic [31:0]   rdData  = '0;
  logic          rdValid = 1'b0;

  txn_t expTx[$];
  txn_t obsTx[$];
  txn_t stallTx[$];

  assign busIf.avm_readdata      = rdData;
  assign busIf.avm_readdatavalid = rdValid;
  assign busIf.avm_waitrequest   = busIf.avm_write && (writeCycles < stallWant);

  // RAM model: stalls the first stallWant write cycles of each run, stores
  // writes (with bit0 flipped at faultAddr when enabled) and returns reads
  // one cycle after they are accepted.
  always @(posedge clk) begin
    if (!busy) begin
      writeCycles <= 0;
    end else if (busIf.avm_write) begin
      writeCycles <= writeCycles + 1;
    end
    rdValid <= 1'b0;
    if (busIf.avm_chipselect && busIf.avm_write && !busIf.avm_waitrequest) begin
      mem[busIf.avm_address] <= busIf.avm_writedata ^
        {31'b0, faultEn && (busIf.avm_address == faultAddr)};
    end
    if (busIf.avm_chipselect && busIf.avm_read && !busIf.avm_waitrequest) begin
      rdValid <= 1'b1;
      rdData  <= mem[busIf.avm_address];
    end
  end

  // Bus monitor, sampling mid-cycle: accepted writes/reads go to obsTx,
  // write cycles held by waitrequest go to stallTx.
  always @(negedge clk) begin
    if (busIf.avm_chipselect && busIf.avm_write) begin
      if (busIf.avm_waitrequest) begin
        stallTx.push_back('{1'b0, busIf.avm_address, busIf.avm_writedata});
      end else begin
        obsTx.push_back('{1'b0, busIf.avm_address, busIf.avm_writedata});
      end
    end
    if (busIf.avm_chipselect && busIf.avm_read && !busIf.avm_waitrequest) begin
      obsTx.push_back('{1'b1, busIf.avm_address, 32'h0});
    end
  end

  function automatic logic [31:0] pat(input logic [31:0] s, input int i);
    logic [15:0] x;
    x = i[15:0];
    return s ^ {~x, x};
  endfunction

  // Queue the expected write phase and, in verify mode, the read phase.
  task automatic pushExpected(input int base, input int num, input logic [31:0] s, input logic m);
    for (int i = 0; i < num; i++) begin
      expTx.push_back('{1'b0, AW'((base + i) % DEPTH), pat(s, i)});
    end
    if (m) begin
      for (int i = 0; i < num; i++) begin
        expTx.push_back('{1'b1, AW'((base + i) % DEPTH), 32'h0});
      end
    end
  endtask

  // Launch one run and wait (bounded) for done; reports the cycle count
  // from the accepting edge and the result outputs seen with done.
  task automatic applyStimulus(input int base, input int num, input logic [31:0] s,
                               input logic m, output int cycles, output logic sawDone,
                               output logic passObs, output logic [ECW-1:0] errObs,
                               output logic [AW-1:0] firstObs);
    @(negedge clk);
    baseAddr = AW'(base);
    numWords = (AW+1)'(num);
    seed     = s;
    mode     = m;
    start    = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    cycles = 1;
    while (!done && cycles < 2000) begin
      @(negedge clk);
      cycles++;
    end
    sawDone  = done;
    passObs  = pass;
    errObs   = errCount;
    firstObs = firstErrAddr;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    start = 1'b0; mode = 1'b0; baseAddr = '0; numWords = '0; seed = '0;
    repeat (3) @(negedge clk);
    compared++;
    if ({busy, done, pass} !== 3'b000) begin
      mismatched++;
      $display("[TB] FAIL reset_status: got busy/done/pass=%b want 000", {busy, done, pass});
    end
    compared++;
    if ({busIf.avm_chipselect, busIf.avm_write, busIf.avm_read} !== 3'b000) begin
      mismatched++;
      $display("[TB] FAIL reset_strobes: got cs/wr/rd=%b want 000",
               {busIf.avm_chipselect, busIf.avm_write, busIf.avm_read});
    end
    compared++;
    if ({busIf.avm_address, busIf.avm_writedata, errCount, firstErrAddr} !== '0) begin
      mismatched++;
      $display("[TB] FAIL reset_values: got addr=%h wdata=%h err=%h first=%h want all 0",
               busIf.avm_address, busIf.avm_writedata, errCount, firstErrAddr);
    end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_fill(output int cycles);
    logic sawDone, passObs; logic [ECW-1:0] errObs; logic [AW-1:0] firstObs;
    txn_t e, o;
    expTx.push_back('{1'b0, 14'h10, 32'h5A5A0000});
    expTx.push_back('{1'b0, 14'h11, 32'h5A5B0001});
    expTx.push_back('{1'b0, 14'h12, 32'h5A580002});
    expTx.push_back('{1'b0, 14'h13, 32'h5A590003});
    applyStimulus(32'h10, 4, 32'hA5A50000, 1'b0, cycles, sawDone, passObs, errObs, firstObs);
    while (expTx.size() > 0) begin
      e = expTx.pop_front();
      compared++;
      if (obsTx.size() == 0) begin
        mismatched++;
        $display("[TB] FAIL fill_txn: got none want wr %h@%h", e.data, e.addr);
      end else begin
        o = obsTx.pop_front();
        if ({o.isRead, o.addr, o.data} !== {e.isRead, e.addr, e.data}) begin
          mismatched++;
          $display("[TB] FAIL fill_txn: got rd=%b %h@%h want rd=%b %h@%h",
                   o.isRead, o.data, o.addr, e.isRead, e.data, e.addr);
        end
      end
    end
    compared++;
    if (obsTx.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL fill_extra: got %0d extra bus cycles want 0", obsTx.size());
      obsTx.delete();
    end
    compared++;
    if ({sawDone, passObs} !== 2'b11) begin
      mismatched++;
      $display("[TB] FAIL fill_done_pass: got done/pass=%b want 11", {sawDone, passObs});
    end
  endtask

  task automatic test_verify(input logic withFault);
    logic sawDone, passObs; logic [ECW-1:0] errObs; logic [AW-1:0] firstObs;
    int cycles;
    txn_t e, o;
    faultEn   = withFault;
    faultAddr = 14'h103;
    pushExpected(32'h100, 8, 32'h12345678, 1'b1);
    applyStimulus(32'h100, 8, 32'h12345678, 1'b1, cycles, sawDone, passObs, errObs, firstObs);
    faultEn = 1'b0;
    while (expTx.size() > 0) begin
      e = expTx.pop_front();
      compared++;
      if (obsTx.size() == 0) begin
        mismatched++;
        $display("[TB] FAIL verify_txn: got none want rd=%b @%h", e.isRead, e.addr);
      end else begin
        o = obsTx.pop_front();
        if ({o.isRead, o.addr, o.data} !== {e.isRead, e.addr, e.data}) begin
          mismatched++;
          $display("[TB] FAIL verify_txn: got rd=%b %h@%h want rd=%b %h@%h",
                   o.isRead, o.data, o.addr, e.isRead, e.data, e.addr);
        end
      end
    end
    compared++;
    if (obsTx.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL verify_extra: got %0d extra bus cycles want 0", obsTx.size());
      obsTx.delete();
    end
    compared++;
    if (withFault) begin
      if ({sawDone, passObs, errObs, firstObs} !== {1'b1, 1'b0, 16'd1, 14'h103}) begin
        mismatched++;
        $display("[TB] FAIL fault_result: got done=%b pass=%b err=%0d first=%h want 1 0 1 103",
                 sawDone, passObs, errObs, firstObs);
      end
    end else begin
      if ({sawDone, passObs, errObs, firstObs} !== {1'b1, 1'b1, 16'd0, 14'h0}) begin
        mismatched++;
        $display("[TB] FAIL verify_result: got done=%b pass=%b err=%0d first=%h want 1 1 0 0",
                 sawDone, passObs, errObs, firstObs);
      end
    end
  endtask

  task automatic test_stall(input int baseCycles);
    logic sawDone, passObs; logic [ECW-1:0] errObs; logic [AW-1:0] firstObs;
    int cycles;
    txn_t e, o;
    stallTx.delete();
    stallWant = 3;
    pushExpected(32'h10, 4, 32'hA5A50000, 1'b0);
    applyStimulus(32'h10, 4, 32'hA5A50000, 1'b0, cycles, sawDone, passObs, errObs, firstObs);
    stallWant = 0;
    compared++;
    if (stallTx.size() != 3) begin
      mismatched++;
      $display("[TB] FAIL stall_count: got %0d stalled cycles want 3", stallTx.size());
    end
    while (stallTx.size() > 0) begin
      o = stallTx.pop_front();
      compared++;
      if ({o.addr, o.data} !== {14'h10, 32'h5A5A0000}) begin
        mismatched++;
        $display("[TB] FAIL stall_hold: got %h@%h want 5a5a0000@0010", o.data, o.addr);
      end
    end
    while (expTx.size() > 0) begin
      e = expTx.pop_front();
      compared++;
      if (obsTx.size() == 0) begin
        mismatched++;
        $display("[TB] FAIL stall_txn: got none want %h@%h", e.data, e.addr);
      end else begin
        o = obsTx.pop_front();
        if ({o.isRead, o.addr, o.data} !== {e.isRead, e.addr, e.data}) begin
          mismatched++;
          $display("[TB] FAIL stall_txn: got %h@%h want %h@%h", o.data, o.addr, e.data, e.addr);
        end
      end
    end
    obsTx.delete();
    compared++;
    if (!sawDone || cycles != baseCycles + 3) begin
      mismatched++;
      $display("[TB] FAIL stall_length: got %0d cycles (done=%b) want %0d", cycles, sawDone, baseCycles + 3);
    end
  endtask

  task automatic test_zero_length;
    logic sawDone, passObs; logic [ECW-1:0] errObs; logic [AW-1:0] firstObs;
    int cycles;
    stallTx.delete();
    applyStimulus(32'h40, 0, 32'hDEADBEEF, 1'b1, cycles, sawDone, passObs, errObs, firstObs);
    compared++;
    if (!sawDone || cycles > 2 || passObs !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL zero_len: got done=%b cycles=%0d pass=%b want done within 2, pass 1",
               sawDone, cycles, passObs);
    end
    compared++;
    if (obsTx.size() + stallTx.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL zero_strobes: got %0d bus cycles want 0", obsTx.size() + stallTx.size());
      obsTx.delete();
    end
  endtask

  task automatic test_wrap;
    logic sawDone, passObs; logic [ECW-1:0] errObs; logic [AW-1:0] firstObs;
    int cycles;
    logic [AW-1:0] wantAddr [4];
    txn_t o;
    wantAddr[0] = 14'd10238; wantAddr[1] = 14'd10239; wantAddr[2] = 14'd0; wantAddr[3] = 14'd1;
    applyStimulus(10238, 4, 32'h0F0F1234, 1'b1, cycles, sawDone, passObs, errObs, firstObs);
    for (int k = 0; k < 8; k++) begin
      compared++;
      if (obsTx.size() == 0) begin
        mismatched++;
        $display("[TB] FAIL wrap_txn: got none want rd=%b @%0d", k >= 4, wantAddr[k % 4]);
      end else begin
        o = obsTx.pop_front();
        if ({o.isRead, o.addr} !== {(k >= 4), wantAddr[k % 4]} ||
            (k < 4 && o.data !== pat(32'h0F0F1234, k))) begin
          mismatched++;
          $display("[TB] FAIL wrap_txn: got rd=%b %h@%0d want rd=%b @%0d",
                   o.isRead, o.data, o.addr, k >= 4, wantAddr[k % 4]);
        end
      end
    end
    obsTx.delete();
    compared++;
    if ({sawDone, passObs} !== 2'b11) begin
      mismatched++;
      $display("[TB] FAIL wrap_result: got done/pass=%b want 11", {sawDone, passObs});
    end
  endtask

  task automatic test_reset_midrun;
    int nAfter;
    txn_t e, o;
    pushExpected(32'h200, 20, 32'hCAFEF00D, 1'b0);
    @(negedge clk);
    baseAddr = 14'h200; numWords = 15'd20; seed = 32'hCAFEF00D; mode = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    compared++;
    if ({busy, done, pass, busIf.avm_chipselect, busIf.avm_write, busIf.avm_read} !== 6'b0 ||
        {busIf.avm_address, busIf.avm_writedata, errCount, firstErrAddr} !== '0) begin
      mismatched++;
      $display("[TB] FAIL midrun_reset: got busy=%b cs=%b wr=%b addr=%h wdata=%h want all 0",
               busy, busIf.avm_chipselect, busIf.avm_write, busIf.avm_address, busIf.avm_writedata);
    end
    @(negedge clk);
    reset_n = 1'b1;
    nAfter = obsTx.size();
    repeat (6) @(negedge clk);
    compared++;
    if (obsTx.size() != nAfter || busy !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL midrun_quiet: got %0d bus cycles busy=%b after reset want %0d busy=0",
               obsTx.size(), busy, nAfter);
    end
    compared++;
    if (obsTx.size() == 0) begin
      mismatched++;
      $display("[TB] FAIL midrun_progress: got 0 writes before reset want some");
    end
    while (obsTx.size() > 0) begin
      o = obsTx.pop_front();
      e = expTx.pop_front();
      compared++;
      if ({o.isRead, o.addr, o.data} !== {e.isRead, e.addr, e.data}) begin
        mismatched++;
        $display("[TB] FAIL midrun_txn: got %h@%h want %h@%h", o.data, o.addr, e.data, e.addr);
      end
    end
    expTx.delete();
  endtask

  // Scenario sequence; every task compares its own results inline.
  initial begin
    int fillCycles;
    test_reset();
    test_fill(fillCycles);
    test_verify(1'b0);
    test_verify(1'b1);
    test_stall(fillCycles);
    test_zero_length();
    test_wrap();
    test_reset_midrun();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
